lsu_mc: RTL

Multi-cycle load/store unit between EXU and the data-memory port. Replaces the single-cycle combinational LSU with a DATA_WIDTH-parametrised handshaked block. Each access is a request/response transaction with RAM, byte-lane alignment and sign/zero extension are done internally, and misaligned accesses are optionally split into two bus beats. One access is in flight at a time.

---
 rtl/lsu_mc.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mc.sv
// lsu_mc: multi-cycle handshaked load/store unit between EXU and the data-memory port.
// Byte-lane alignment and sign/zero extension are done internally; one access in flight.
// Build option LSU_MISALIGN_EN: word-crossing accesses are split into two RAM beats;
// without it, accesses not aligned to their size are rejected with o_lsu_misalign.
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 3
`endif
`ifndef RAM_BYT_1_S
`define RAM_BYT_1_S 3'b000
`endif
`ifndef RAM_BYT_2_S
`define RAM_BYT_2_S 3'b001
`endif
`ifndef RAM_BYT_4_S
`define RAM_BYT_4_S 3'b010
`endif
`ifndef RAM_BYT_1_U
`define RAM_BYT_1_U 3'b100
`endif
`ifndef RAM_BYT_2_U
`define RAM_BYT_2_U 3'b101
`endif
`ifndef RAM_BYT_4_U
`define RAM_BYT_4_U 3'b110
`endif

module lsu_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst_n,
    input  logic                    i_lsu_req_valid,
    output logic                    o_lsu_req_ready,
    input  logic                    i_idu_ctr_ram_wr_en,
    input  logic [`ARGS_WIDTH-1:0]  i_idu_ctr_ram_byt,
    input  logic [ADDR_WIDTH-1:0]   i_exu_res,
    input  logic [DATA_WIDTH-1:0]   i_gpr_rs2_data,
    output logic                    o_lsu_ram_req_valid,
    input  logic                    i_ram_req_ready,
    output logic                    o_lsu_ram_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_lsu_ram_addr,
    output logic [DATA_WIDTH-1:0]   o_lsu_ram_wr_data,
    output logic [DATA_WIDTH/8-1:0] o_lsu_ram_wr_mask,
    input  logic                    i_ram_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   i_ram_rd_data,
    output logic                    o_lsu_rsp_valid,
    input  logic                    i_sys_ready,
    output logic [DATA_WIDTH-1:0]   o_lsu_gpr_wr_data,
    output logic                    o_lsu_misalign
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = $clog2(NB);
    localparam logic [OW:0] NBV = (OW + 1)'(NB);
    localparam logic [2:0] IDLE = 3'd0, REQ0 = 3'd1, RSP0 = 3'd2, DONE = 3'd5;
`ifdef LSU_MISALIGN_EN
    localparam logic [2:0] REQ1 = 3'd3, RSP1 = 3'd4;
`endif

    logic [2:0]            state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic [1:0]            lg_q, lg_d;
    logic                  sg_q, sg_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] rs2_q, rs2_d;
    logic [DATA_WIDTH-1:0] rd0_q, rd0_d;
    logic                  ram_wr_en_q, ram_wr_en_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wr_data_q, ram_wr_data_d;
    logic [NB-1:0]         ram_wr_mask_q, ram_wr_mask_d;
    logic [1:0]            byt_lg;
    logic                  byt_sg;
    logic                  mis;
    logic                  beat1;
    logic                  in_req;
    logic [OW-1:0]         off_d, off_q;
    logic [OW:0]           shamt_d;
    logic [ADDR_WIDTH-1:0] base_d;
    logic [NB-1:0]         lane_m;
    logic [DATA_WIDTH-1:0] raw, keep, ext;
    logic                  sbit;
`ifdef LSU_MISALIGN_EN
    logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
    logic                  cross;
`else
    logic                  mis_q, mis_d;
    logic                  bad;
`endif

    assign off_q = addr_q[OW-1:0];

    // Decode the size/sign code; anything unrecognised behaves as an unsigned word.
    always_comb begin
        byt_lg = (i_idu_ctr_ram_byt == `RAM_BYT_1_S || i_idu_ctr_ram_byt == `RAM_BYT_1_U) ? 2'd0 :
                 (i_idu_ctr_ram_byt == `RAM_BYT_2_S || i_idu_ctr_ram_byt == `RAM_BYT_2_U) ? 2'd1 : 2'd2;
        byt_sg = i_idu_ctr_ram_byt == `RAM_BYT_1_S || i_idu_ctr_ram_byt == `RAM_BYT_2_S ||
                 i_idu_ctr_ram_byt == `RAM_BYT_4_S;
    end

`ifdef LSU_MISALIGN_EN
    // A second beat is needed when the access runs past the end of the first word.
    always_comb cross = ({1'b0, off_q} + ({{OW{1'b0}}, 1'b1} << lg_q)) > NBV;
    assign mis = 1'b0;
`else
    // Reject an access whose offset is not a multiple of its size.
    always_comb bad = byt_lg == 2'd0 ? 1'b0 : byt_lg == 2'd1 ? i_exu_res[0] : |i_exu_res[1:0];
    assign mis = mis_q;
`endif

    // Transaction sequencing: accept, issue beat(s), collect response(s), complete.
    always_comb begin
        state_d = state_q;
        wr_en_d = wr_en_q;
        lg_d    = lg_q;
        sg_d    = sg_q;
        addr_d  = addr_q;
        rs2_d   = rs2_q;
        rd0_d   = rd0_q;
`ifdef LSU_MISALIGN_EN
        rd1_d   = rd1_q;
`else
        mis_d   = mis_q;
`endif
        case (state_q)
            IDLE: if (i_lsu_req_valid) begin
                wr_en_d = i_idu_ctr_ram_wr_en;
                lg_d    = byt_lg;
                sg_d    = byt_sg;
                addr_d  = i_exu_res;
                rs2_d   = i_gpr_rs2_data;
`ifdef LSU_MISALIGN_EN
                state_d = REQ0;
`else
                mis_d   = bad;
                state_d = bad ? DONE : REQ0;
`endif
            end
            REQ0: state_d = i_ram_req_ready ? RSP0 : REQ0;
            RSP0: if (i_ram_rsp_valid) begin
                rd0_d   = i_ram_rd_data;
`ifdef LSU_MISALIGN_EN
                state_d = cross ? REQ1 : DONE;
`else
                state_d = DONE;
`endif
            end
`ifdef LSU_MISALIGN_EN
            REQ1: state_d = i_ram_req_ready ? RSP1 : REQ1;
            RSP1: if (i_ram_rsp_valid) begin
                rd1_d   = i_ram_rd_data;
                state_d = DONE;
            end
`endif
            DONE: state_d = i_sys_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Beat fields are derived from the next-cycle view so the RAM outputs are registered yet valid on REQx entry.
    always_comb begin
`ifdef LSU_MISALIGN_EN
        beat1 = state_d == REQ1;
`else
        beat1 = 1'b0;
`endif
        in_req        = state_d == REQ0 || beat1;
        off_d         = addr_d[OW-1:0];
        shamt_d       = NBV - {1'b0, off_d};
        base_d        = {addr_d[ADDR_WIDTH-1:OW], {OW{1'b0}}};
        lane_m        = lg_d == 2'd0 ? NB'(1) : lg_d == 2'd1 ? NB'(3) : NB'(15);
        ram_wr_en_d   = in_req & wr_en_d;
        ram_addr_d    = !in_req ? '0 : beat1 ? base_d + ADDR_WIDTH'(NB) : base_d;
        ram_wr_data_d = !(in_req & wr_en_d) ? '0 :
                        beat1 ? rs2_d >> {shamt_d, 3'b000} : rs2_d << {off_d, 3'b000};
        ram_wr_mask_d = !in_req ? '0 : beat1 ? lane_m >> shamt_d : lane_m << off_d;
    end

    // Realign the captured beat(s) to bit 0 and extend the low n bytes.
    always_comb begin
        raw  = rd0_q >> {off_q, 3'b000};
`ifdef LSU_MISALIGN_EN
        raw  = raw | (rd1_q << {NBV - {1'b0, off_q}, 3'b000});
`endif
        keep = ~({DATA_WIDTH{1'b1}} << (7'd8 << lg_q));
        sbit = lg_q == 2'd0 ? raw[7] : lg_q == 2'd1 ? raw[15] : raw[31];
        ext  = (raw & keep) | ((sg_q & sbit) ? ~keep : '0);
    end

    assign o_lsu_req_ready     = state_q == IDLE;
`ifdef LSU_MISALIGN_EN
    assign o_lsu_ram_req_valid = state_q == REQ0 || state_q == REQ1;
`else
    assign o_lsu_ram_req_valid = state_q == REQ0;
`endif
    assign o_lsu_ram_wr_en     = ram_wr_en_q;
    assign o_lsu_ram_addr      = ram_addr_q;
    assign o_lsu_ram_wr_data   = ram_wr_data_q;
    assign o_lsu_ram_wr_mask   = ram_wr_mask_q;
    assign o_lsu_rsp_valid     = state_q == DONE;
    assign o_lsu_misalign      = o_lsu_rsp_valid & mis;
    assign o_lsu_gpr_wr_data   = (o_lsu_rsp_valid && !wr_en_q && !mis) ? ext : '0;

    // State, latched access and registered RAM-side outputs; reset aborts any access at once.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q       <= IDLE;
            wr_en_q       <= 1'b0;
            lg_q          <= 2'd0;
            sg_q          <= 1'b0;
            addr_q        <= '0;
            rs2_q         <= '0;
            rd0_q         <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            ram_wr_mask_q <= '0;
`ifdef LSU_MISALIGN_EN
            rd1_q         <= '0;
`else
            mis_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            wr_en_q       <= wr_en_d;
            lg_q          <= lg_d;
            sg_q          <= sg_d;
            addr_q        <= addr_d;
            rs2_q         <= rs2_d;
            rd0_q         <= rd0_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            ram_wr_mask_q <= ram_wr_mask_d;
`ifdef LSU_MISALIGN_EN
            rd1_q         <= rd1_d;
`else
            mis_q         <= mis_d;
`endif
        end
    end
endmodule
